// File: rtl/mem_arbiter_if.sv
// Bus bundle between the arbiter, its two requesters (core, DMA) and the memory port.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if;
    logic        c_req;
    logic        c_we;
    logic [31:0] c_adr;
    logic [31:0] c_wd;
    logic [31:0] c_rd;
    logic        c_done;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_adr;
    logic [31:0] d_wd;
    logic [31:0] d_rd;
    logic        d_done;

    logic        m_req;
    logic        m_we;
    logic [31:0] m_adr;
    logic [31:0] m_wd;
    logic [31:0] m_rd;
    logic        m_ack;

    logic        err;
    logic        err_clr;

    modport slave (
        input  c_req, c_we, c_adr, c_wd,
        output c_rd, c_done,
        input  d_req, d_we, d_adr, d_wd,
        output d_rd, d_done,
        output m_req, m_we, m_adr, m_wd,
        input  m_rd, m_ack,
        output err,
        input  err_clr
    );

    modport master (
        output c_req, c_we, c_adr, c_wd,
        input  c_rd, c_done,
        output d_req, d_we, d_adr, d_wd,
        input  d_rd, d_done,
        input  m_req, m_we, m_adr, m_wd,
        output m_rd, m_ack,
        input  err,
        output err_clr
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master (core/DMA) round-robin arbiter onto a single memory port, with a
// per-transaction wait-cycle timeout that aborts the access and raises a sticky err.
module mem_arbiter #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic          clk,
    input  logic          reset_n,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_C = 2'd1,
        BUSY_D = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

    state_t      r_state;
    state_t      w_state_next;

    logic        r_owner;        // 0 = core, 1 = DMA
    logic        r_last_grant;   // 0 = core, 1 = DMA
    logic        r_m_req;
    logic        r_m_we;
    logic [31:0] r_m_adr;
    logic [31:0] r_m_wd;
    logic [31:0] r_rd [2];
    logic [1:0]  r_done;
    logic        r_err;
    logic [7:0]  r_wait;

    logic        w_grant_c;
    logic        w_grant_d;
    logic        w_busy;
    logic        w_ack;
    logic        w_timeout;
    logic        w_finish;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_grant_c    = 1'b0;
        w_grant_d    = 1'b0;
        w_ack        = 1'b0;
        w_timeout    = 1'b0;
        w_busy       = 1'b0;
        case (r_state)
            IDLE: begin
                // On a tie the requester that was not served last wins.
                if (bus.c_req && (!bus.d_req || r_last_grant)) begin
                    w_grant_c    = 1'b1;
                    w_state_next = BUSY_C;
                end else if (bus.d_req) begin
                    w_grant_d    = 1'b1;
                    w_state_next = BUSY_D;
                end
            end
            BUSY_C, BUSY_D: begin
                w_busy = 1'b1;
                if (bus.m_ack) begin
                    w_ack        = 1'b1;
                    w_state_next = DONE;
                end else if (r_wait == LAST_WAIT) begin
                    w_timeout    = 1'b1;
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign w_finish = w_ack || w_timeout;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_m_req      <= 1'b0;
            r_m_we       <= 1'b0;
            r_m_adr      <= '0;
            r_m_wd       <= '0;
            r_rd[0]      <= '0;
            r_rd[1]      <= '0;
            r_done       <= '0;
            r_err        <= 1'b0;
            r_wait       <= '0;
        end else begin
            r_done <= '0;
            if (w_grant_c || w_grant_d) begin
                r_m_req      <= 1'b1;
                r_owner      <= w_grant_d;
                r_last_grant <= w_grant_d;
                r_wait       <= '0;
                r_m_we       <= w_grant_d ? bus.d_we  : bus.c_we;
                r_m_adr      <= w_grant_d ? bus.d_adr : bus.c_adr;
                r_m_wd       <= w_grant_d ? bus.d_wd  : bus.c_wd;
            end
            if (w_busy && !bus.m_ack) begin
                r_wait <= r_wait + 8'd1;
            end
            if (w_finish) begin
                r_m_req         <= 1'b0;
                r_done[r_owner] <= 1'b1;
                // An aborted access returns zero; a completed write keeps the old read data.
                if (w_timeout) begin
                    r_rd[r_owner] <= '0;
                end else if (!r_m_we) begin
                    r_rd[r_owner] <= bus.m_rd;
                end
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end else if (bus.err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    assign bus.m_req  = r_m_req;
    assign bus.m_we   = r_m_we;
    assign bus.m_adr  = r_m_adr;
    assign bus.m_wd   = r_m_wd;
    assign bus.c_rd   = r_rd[0];
    assign bus.d_rd   = r_rd[1];
    assign bus.c_done = r_done[0];
    assign bus.d_done = r_done[1];
    assign bus.err    = r_err;
endmodule
